// File: rtl/wb_b3_defs.sv
// rtl/wb_b3_defs.sv - Wishbone B3 cycle-type and burst-type codes shared by masters and slaves
//
// Purpose: single source of the CTI/BTE encodings plus a command-length helper.
// Ports: none (package).

package wb_b3_defs;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // A zero-length command is executed as a single beat.
  function automatic logic [4:0] norm_len(input logic [4:0] len);
    return (len == 5'd0) ? 5'd1 : len;
  endfunction

endpackage

// File: rtl/wb_b3_burst_adr.sv
// rtl/wb_b3_burst_adr.sv - next word address for Wishbone B3 linear and wrapping bursts
//
// Purpose: given the current beat address and burst type, produce the address
//          of the following beat. Bits outside the wrap window are unchanged.
// Ports:
//   adr_i [aw]  current byte address
//   bte_i [2]   burst type extension
//   adr_o [aw]  next byte address, bits [1:0] forced to zero

module wb_b3_burst_adr
  import wb_b3_defs::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-1:0] adr_i,
  input  logic [1:0]    bte_i,
  output logic [aw-1:0] adr_o
);

  logic [aw-1:0] mask;
  logic [aw-1:0] inc;

  // mask selects the byte-address bits that take the incremented value;
  // the rest keep the current address so the burst wraps inside its window.
  always_comb begin
    mask = '1;
    case (bte_i)
      BTE_WRAP4:  mask = aw'(32'h0000_000F);
      BTE_WRAP8:  mask = aw'(32'h0000_001F);
      BTE_WRAP16: mask = aw'(32'h0000_003F);
      default:    mask = '1;
    endcase
    inc   = adr_i + aw'(4);
    adr_o = ((adr_i & ~mask) | (inc & mask)) & ~aw'(3);
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// rtl/wb_b3_burst_master.sv - Wishbone B3 burst master with retry back-off and write buffer
//
// Purpose: executes one read or write command of 1..16 beats as a Wishbone B3
//          classic or incrementing/wrapping burst, with rty back-off and abort.
// Ports:
//   wb_clk_i, wb_rst_i                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_we, cmd_adr, cmd_len, cmd_bte, cmd_sel   command
//   wr_valid/wr_ready, wr_data            write data stream
//   rd_valid, rd_data                     read data, one pulse per acked beat
//   done, done_err                        end-of-command pulse and error flag
//   wb_*                                  Wishbone B3 master interface

module wb_b3_burst_master
  import wb_b3_defs::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int max_retry = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [aw-1:0] cmd_adr,
  input  logic [4:0]    cmd_len,
  input  logic [1:0]    cmd_bte,
  input  logic [3:0]    cmd_sel,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [dw-1:0] wr_data,
  output logic          rd_valid,
  output logic [dw-1:0] rd_data,
  output logic          done,
  output logic          done_err,
  output logic [aw-1:0] wb_adr_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [dw-1:0] wb_dat_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BACKOFF} state_e;

  localparam int RW = $clog2(max_retry + 1) + 1;

  state_e        state_q;
  logic          we_q;
  logic [aw-1:0] adr_q;
  logic [1:0]    bte_q;
  logic [3:0]    sel_q;
  logic [4:0]    rem_q;       // beats not yet acked
  logic [4:0]    load_q;      // write words not yet taken into the buffer
  logic          classic_q;   // current cycle started with one beat left
  logic          buf_full_q;
  logic [dw-1:0] buf_q;
  logic [RW-1:0] retry_q;
  logic          bo_cnt_q;
  logic          rd_valid_q;
  logic [dw-1:0] rd_data_q;
  logic          done_q;
  logic          done_err_q;

  logic [aw-1:0] adr_d;
  logic          active;
  logic          stb;
  logic          ack_eff;
  logic          err_eff;
  logic          rty_eff;
  logic          load;

  wb_b3_burst_adr #(.aw(aw)) u_adr (
    .adr_i (adr_q),
    .bte_i (bte_q),
    .adr_o (adr_d)
  );

  assign active = (state_q == S_ACTIVE);
  // Writes only strobe while a word sits in the buffer; reads strobe always.
  assign stb    = active && (!we_q || buf_full_q);

  // Responses count only with stb high; err beats rty beats ack.
  assign err_eff = stb && wb_err_i;
  assign rty_eff = stb && wb_rty_i && !wb_err_i;
  assign ack_eff = stb && wb_ack_i && !wb_err_i && !wb_rty_i;

  // Refill in the ack cycle keeps stb continuously high.
  assign wr_ready  = active && we_q && (load_q != 5'd0) && (!buf_full_q || ack_eff);
  assign load      = wr_valid && wr_ready;
  assign cmd_ready = (state_q == S_IDLE) && !done_q;

  assign wb_cyc_o = active;
  assign wb_stb_o = stb;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = buf_q;
  assign wb_cti_o = (!active || classic_q) ? CTI_CLASSIC :
                    (rem_q == 5'd1)        ? CTI_EOB : CTI_INCR;
  assign wb_bte_o = (active && !classic_q) ? bte_q : 2'b00;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign done_err = done_err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      bte_q      <= 2'b00;
      sel_q      <= 4'h0;
      rem_q      <= 5'd0;
      load_q     <= 5'd0;
      classic_q  <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      retry_q    <= '0;
      bo_cnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_q    <= S_ACTIVE;
            we_q       <= cmd_we;
            adr_q      <= cmd_adr & ~aw'(3);
            bte_q      <= cmd_bte;
            sel_q      <= cmd_sel;
            rem_q      <= norm_len(cmd_len);
            load_q     <= cmd_we ? norm_len(cmd_len) : 5'd0;
            classic_q  <= (norm_len(cmd_len) == 5'd1);
            buf_full_q <= 1'b0;
            retry_q    <= '0;
          end
        end
        S_ACTIVE: begin
          if (load) begin
            buf_q  <= wr_data;
            load_q <= load_q - 5'd1;
          end
          if (err_eff || (rty_eff && retry_q == RW'(max_retry))) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
            buf_full_q <= 1'b0;
            load_q     <= 5'd0;
          end else if (rty_eff) begin
            // Buffered write word is kept so the beat replays after back-off.
            retry_q  <= retry_q + RW'(1);
            state_q  <= S_BACKOFF;
            bo_cnt_q <= 1'b0;
          end else if (ack_eff) begin
            retry_q    <= '0;
            adr_q      <= adr_d;
            rem_q      <= rem_q - 5'd1;
            buf_full_q <= load;
            if (!we_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= wb_dat_i;
            end
            if (rem_q == 5'd1) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end else if (load) begin
            buf_full_q <= 1'b1;
          end
        end
        S_BACKOFF: begin
          bo_cnt_q <= 1'b1;
          if (bo_cnt_q) begin
            state_q   <= S_ACTIVE;
            classic_q <= (rem_q == 5'd1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// tb/tb_wb_b3_burst_master.sv - scoreboard bench for wb_b3_burst_master

module tb_wb_b3_burst_master;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [4:0]  cmd_len = '0;
  logic [1:0]  cmd_bte = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_ready, wr_ready, rd_valid, done, done_err;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0, rd_data;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  always #5 clk = ~clk;

  wb_b3_burst_master #(.dw(32), .aw(32), .max_retry(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
    .wb_adr_o(wb_adr_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  logic        done_q[$];
  int          resp_q[$];   // 1 ack, 2 err, 3 rty; empty queue means ack
  logic [31:0] wq[$];

  int errors = 0, checks = 0;
  int consumed = 0, stall_idx = -1, stall_left = 0, stb_low = 0;
  int acks = 0, rd_cnt = 0, rty_cnt = 0, gap = 0, done_cnt = 0;
  logic seen_stb = 1'b0, prev_end = 1'b0, in_gap = 1'b0, mute = 1'b0;
  logic [31:0] low_adr = '0;

  int          code;
  beat_t       mb;
  logic [31:0] mr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic [2:0] c, input logic [1:0] bt,
                          input logic w, input logic [3:0] s, input logic [31:0] d);
    beat_t b;
    b.adr = a; b.cti = c; b.bte = bt; b.we = w; b.sel = s; b.dat = d;
    beat_q.push_back(b);
  endtask

  // Slave model, write-data source and monitor share one process so the
  // response, the wr handshake and the checks see a consistent cycle.
  initial forever begin
    @(negedge clk);
    code = 0;
    if (!mute && wb_cyc_o && wb_stb_o)
      code = (resp_q.size() > 0) ? resp_q.pop_front() : 1;
    // Spurious ack while stb is low must be ignored by the master.
    wb_ack_i = (code == 1) || (!mute && wb_cyc_o && !wb_stb_o);
    wb_err_i = (code == 2);
    wb_rty_i = (code == 3);
    wb_dat_i = 32'hA500_0000 ^ wb_adr_o;
    wr_valid = (wq.size() > 0) && !(consumed == stall_idx && stall_left > 0);
    wr_data  = (wq.size() > 0) ? wq[0] : 32'h0;
    if (consumed == stall_idx && stall_left > 0 && wb_cyc_o) stall_left--;
    #1;
    if (wb_cyc_o) begin
      if (wb_stb_o) seen_stb = 1'b1;
      else if (seen_stb) begin stb_low++; low_adr = wb_adr_o; end
    end
    if (prev_end) chk("cyc_drop_after_end", wb_cyc_o, 0);
    if (in_gap) begin
      if (!wb_cyc_o) gap++;
      else begin chk("backoff_gap", gap, 2); in_gap = 1'b0; end
    end
    prev_end = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (wb_err_i) prev_end = 1'b1;
      else if (wb_rty_i) begin
        prev_end = 1'b1;
        rty_cnt++;
        if (rty_cnt <= 4) begin in_gap = 1'b1; gap = 0; end
      end else if (wb_ack_i) begin
        acks++;
        if (wb_cti_o == 3'b000 || wb_cti_o == 3'b111) prev_end = 1'b1;
        if (beat_q.size() == 0) chk("beat_expected", beat_q.size() != 0, 1);
        else begin
          mb = beat_q.pop_front();
          chk("beat_adr_cti_bte_we_sel", {wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o},
              {mb.adr, mb.cti, mb.bte, mb.we, mb.sel});
          if (mb.we) chk("beat_dat", wb_dat_o, mb.dat);
        end
      end
    end
    if (wr_valid && wr_ready) begin void'(wq.pop_front()); consumed++; end
    if (rd_valid) begin
      rd_cnt++;
      if (rd_q.size() == 0) chk("rd_expected", rd_q.size() != 0, 1);
      else begin mr = rd_q.pop_front(); chk("rd_data", rd_data, mr); end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) chk("done_expected", done_q.size() != 0, 1);
      else chk("done_err", done_err, done_q.pop_front());
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [4:0] len,
                       input logic [1:0] bte, input logic [3:0] sel);
    seen_stb = 1'b0; stb_low = 0; consumed = 0; acks = 0; rd_cnt = 0; rty_cnt = 0;
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte; cmd_sel = sel; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != start) break;
    end
    chk("done_seen", done_cnt != start, 1);
  endtask

  logic [31:0] t4a [8];
  int dc;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) wb_rst_i = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_rd_done", {rd_valid, done, done_err}, 3'b000);

    // Single classic read; bte on the bus must be 00 despite cmd_bte=01.
    exp_beat(32'h100, 3'b000, 2'b00, 1'b0, 4'hF, 0);
    rd_q.push_back(32'hA500_0100);
    done_q.push_back(1'b0);
    issue(1'b0, 32'h100, 5'd1, 2'b01, 4'hF);
    wait_done();
    chk("t1_acks", acks, 1);
    chk("t1_rd_cnt", rd_cnt, 1);

    // Linear write burst, continuous data and acks.
    wq.push_back(32'h1111_1111); wq.push_back(32'h2222_2222);
    wq.push_back(32'h3333_3333); wq.push_back(32'h4444_4444);
    exp_beat(32'h10, 3'b010, 2'b00, 1'b1, 4'hF, 32'h1111_1111);
    exp_beat(32'h14, 3'b010, 2'b00, 1'b1, 4'hF, 32'h2222_2222);
    exp_beat(32'h18, 3'b010, 2'b00, 1'b1, 4'hF, 32'h3333_3333);
    exp_beat(32'h1C, 3'b111, 2'b00, 1'b1, 4'hF, 32'h4444_4444);
    done_q.push_back(1'b0);
    issue(1'b1, 32'h10, 5'd4, 2'b00, 4'hF);
    wait_done();
    chk("t2_stb_low", stb_low, 0);
    chk("t2_consumed", consumed, 4);

    // Wrap-4 read.
    exp_beat(32'h18, 3'b010, 2'b01, 1'b0, 4'h3, 0);
    exp_beat(32'h1C, 3'b010, 2'b01, 1'b0, 4'h3, 0);
    exp_beat(32'h10, 3'b010, 2'b01, 1'b0, 4'h3, 0);
    exp_beat(32'h14, 3'b111, 2'b01, 1'b0, 4'h3, 0);
    rd_q.push_back(32'hA500_0018); rd_q.push_back(32'hA500_001C);
    rd_q.push_back(32'hA500_0010); rd_q.push_back(32'hA500_0014);
    done_q.push_back(1'b0);
    issue(1'b0, 32'h18, 5'd4, 2'b01, 4'h3);
    wait_done();
    chk("t3_rd_cnt", rd_cnt, 4);

    // Wrap-8 read from 0x3C.
    t4a = '{32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38};
    for (int i = 0; i < 8; i++) begin
      exp_beat(t4a[i], (i == 7) ? 3'b111 : 3'b010, 2'b10, 1'b0, 4'hF, 0);
      rd_q.push_back(32'hA500_0000 | t4a[i]);
    end
    done_q.push_back(1'b0);
    issue(1'b0, 32'h3C, 5'd8, 2'b10, 4'hF);
    wait_done();
    chk("t4_acks", acks, 8);

    // Write with data starvation before the third word.
    stall_idx = 2; stall_left = 2;
    wq.push_back(32'h5555_5555); wq.push_back(32'h6666_6666);
    wq.push_back(32'h7777_7777); wq.push_back(32'h8888_8888);
    exp_beat(32'h10, 3'b010, 2'b00, 1'b1, 4'hF, 32'h5555_5555);
    exp_beat(32'h14, 3'b010, 2'b00, 1'b1, 4'hF, 32'h6666_6666);
    exp_beat(32'h18, 3'b010, 2'b00, 1'b1, 4'hF, 32'h7777_7777);
    exp_beat(32'h1C, 3'b111, 2'b00, 1'b1, 4'hF, 32'h8888_8888);
    done_q.push_back(1'b0);
    issue(1'b1, 32'h10, 5'd4, 2'b00, 4'hF);
    wait_done();
    chk("t5_stb_low", stb_low, 2);
    chk("t5_held_adr", low_adr, 32'h18);
    chk("t5_acks", acks, 4);
    stall_idx = -1;

    // Read burst terminated by err on the third beat.
    resp_q.push_back(1); resp_q.push_back(1); resp_q.push_back(2);
    exp_beat(32'h200, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    exp_beat(32'h204, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    rd_q.push_back(32'hA500_0200); rd_q.push_back(32'hA500_0204);
    done_q.push_back(1'b1);
    issue(1'b0, 32'h200, 5'd8, 2'b00, 4'hF);
    wait_done();
    chk("t6_rd_cnt", rd_cnt, 2);

    // One rty on beat 2, restart at 0x44.
    resp_q.push_back(1); resp_q.push_back(3);
    exp_beat(32'h40, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    exp_beat(32'h44, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    exp_beat(32'h48, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    exp_beat(32'h4C, 3'b111, 2'b00, 1'b0, 4'hF, 0);
    rd_q.push_back(32'hA500_0040); rd_q.push_back(32'hA500_0044);
    rd_q.push_back(32'hA500_0048); rd_q.push_back(32'hA500_004C);
    done_q.push_back(1'b0);
    issue(1'b0, 32'h40, 5'd4, 2'b00, 4'hF);
    wait_done();
    chk("t7_rty_cnt", rty_cnt, 1);
    chk("t7_acks", acks, 4);

    // Five consecutive rty exhaust max_retry=4.
    for (int i = 0; i < 5; i++) resp_q.push_back(3);
    done_q.push_back(1'b1);
    issue(1'b0, 32'h40, 5'd4, 2'b00, 4'hF);
    wait_done();
    chk("t8_rty_cnt", rty_cnt, 5);
    chk("t8_rd_cnt", rd_cnt, 0);

    // len=0 runs as one classic write; address bits [1:0] dropped.
    wq.push_back(32'hCAFE_F00D);
    exp_beat(32'h300, 3'b000, 2'b00, 1'b1, 4'h5, 32'hCAFE_F00D);
    done_q.push_back(1'b0);
    issue(1'b1, 32'h303, 5'd0, 2'b11, 4'h5);
    wait_done();
    chk("t9_consumed", consumed, 1);

    // Reset in the middle of a stalled write burst.
    mute = 1'b1;
    wq.push_back(32'hDEAD_BEEF); wq.push_back(32'h0BAD_F00D);
    issue(1'b1, 32'h80, 5'd4, 2'b00, 4'hF);
    repeat (4) @(negedge clk);
    #2;
    chk("t10_mid_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
    chk("t10_mid_dat", wb_dat_o, 32'hDEAD_BEEF);
    @(negedge clk) wb_rst_i = 1'b1;
    @(negedge clk) wb_rst_i = 1'b0;
    #2;
    chk("t10_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_sel_o}, 0);
    chk("t10_rst_adr_dat", {wb_adr_o, wb_dat_o}, 0);
    chk("t10_rst_ready", {cmd_ready, wr_ready}, 2'b10);
    chk("t10_rst_rd", {rd_valid, rd_data}, 0);
    wq.delete();
    mute = 1'b0;
    dc = done_cnt;
    repeat (5) @(negedge clk);
    #2;
    chk("t10_no_done", done_cnt, dc);

    // Recovery after reset.
    exp_beat(32'h500, 3'b010, 2'b00, 1'b0, 4'hF, 0);
    exp_beat(32'h504, 3'b111, 2'b00, 1'b0, 4'hF, 0);
    rd_q.push_back(32'hA500_0500); rd_q.push_back(32'hA500_0504);
    done_q.push_back(1'b0);
    issue(1'b0, 32'h500, 5'd2, 2'b00, 4'hF);
    wait_done();

    repeat (3) @(negedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_b3_burst_master.md
WB_B3_BURST_MASTER -- requirements
Module: wb_b3_burst_master

Interface
REQ-001 SHALL have parameter dw, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter aw, default 32, address width.
REQ-003 SHALL have parameter max_retry, default 4, consecutive rty responses tolerated per beat before abort.
REQ-004 SHALL have ports: wb_clk_i in 1, sole clock; wb_rst_i in 1, reset, synchronous active-high.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1, 1=write; cmd_adr in aw, byte address, bits[1:0] ignored; cmd_len in 5, beats 1..16, 0 treated as 1; cmd_bte in 2, burst type; cmd_sel in 4, byte lanes for all beats.
REQ-006 SHALL have write-data ports: wr_valid in 1; wr_ready out 1; wr_data in dw.
REQ-007 SHALL have read-data ports: rd_valid out 1, one-cycle pulse per acked read beat; rd_data out dw.
REQ-008 SHALL have status ports: done out 1, one-cycle pulse at command end; done_err out 1, valid with done.
REQ-009 SHALL have Wishbone B3 ports: wb_adr_o out aw; wb_bte_o out 2; wb_cti_o out 3; wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_sel_o out 4; wb_dat_o out dw; wb_dat_i in dw; wb_ack_i, wb_err_i, wb_rty_i in 1 each.

Function
REQ-010 SHALL implement states IDLE, ACTIVE, BACKOFF; IDLE->ACTIVE on cmd_valid&cmd_ready; ACTIVE->IDLE on last-beat ack, on err, or on retry exhaustion; ACTIVE->BACKOFF on rty; BACKOFF->ACTIVE after exactly 2 idle cycles.
REQ-011 SHALL assert cmd_ready only in IDLE and only when done is low; command fields latch on acceptance.
REQ-012 SHALL drive wb_cyc_o high throughout ACTIVE and low in IDLE and BACKOFF.
REQ-013 SHALL use a classic cycle (cti=000) when remaining beats = 1 at cycle start; else cti=010 on every beat except the last, which carries cti=111.
REQ-014 SHALL drive wb_bte_o with latched cmd_bte during bursts and 00 during classic cycles.
REQ-015 SHALL advance wb_adr_o in the same cycle a beat is acked, so the next address is valid on the following clock: bte 00 adr[aw-1:2]+1; 01 wraps adr[3:2]; 10 wraps adr[4:2]; 11 wraps adr[5:2]; upper bits unchanged; wb_adr_o[1:0] always 0.
REQ-016 SHALL, for reads, assert wb_stb_o every ACTIVE cycle; rd_valid=1 and rd_data=wb_dat_i registered one cycle after each ack; consumer has no backpressure.
REQ-017 SHALL, for writes, hold one-word buffer driving wb_dat_o; wr_ready = in ACTIVE, beats remaining to be loaded, and (buffer empty or ack this cycle); stb high only while buffer full; stb deasserted on data starvation with cyc, adr, cti held.
REQ-018 SHALL sustain one beat per clock on continuous ack with continuous wr_valid (no stb bubbles).
REQ-019 SHALL, after ack of a classic cycle, drop stb and cyc next cycle (no double ack).
REQ-020 SHALL, on wb_err_i with stb high, drop cyc/stb next cycle, pulse done with done_err=1, discard buffered write word, consume no further wr_data.
REQ-021 SHALL, on wb_rty_i, enter BACKOFF, then restart at the unacked beat's address with remaining count, recomputing cti per REQ-013; retry counter resets on every ack; retry number max_retry+1 aborts as in REQ-020.
REQ-022 SHALL ignore ack/err/rty while stb is low; err takes priority over rty, rty over ack, when simultaneous.
REQ-023 SHALL pulse done (done_err=0) the cycle after the last beat's ack.

Reset
REQ-024 SHALL, on wb_rst_i at any state including mid-burst, next clock force IDLE; all wb_* outputs 0, cmd_ready 1, wr_ready 0, rd_valid 0, rd_data 0, done 0, done_err 0, buffer empty, counters 0; no done pulse for the aborted command.

Structure
REQ-025 SHALL take CTI codes (000, 010, 111) and BTE codes (00..11) from shared package wb_b3_defs, also used by Wishbone slaves.
REQ-026 SHALL place next-address wrap logic in sub-module wb_b3_burst_adr (inputs adr, bte; output next adr).

Verification
REQ-027 SHALL cover: read len=1 adr 0x100, ack next cycle -> cti 000, one ack, rd_valid once, done=1 done_err=0, cyc low after ack.
REQ-028 SHALL cover: write len=4 bte=00 adr 0x10, wr_valid constant, slave acks every cycle -> adr 0x10,0x14,0x18,0x1C, cti 010,010,010,111, stb never low, 4 words consumed.
REQ-029 SHALL cover: read len=4 bte=01 adr 0x18 -> adr 0x18,0x1C,0x10,0x14; len=8 bte=10 adr 0x3C -> wraps to 0x20.
REQ-030 SHALL cover: write len=4, wr_valid low 2 cycles before beat 3 -> stb low 2 cycles, cyc high, adr 0x18 held, 4 acks total.
REQ-031 SHALL cover: read len=8, err on beat 3 -> exactly 2 rd_valid pulses, cyc low next cycle, done_err=1.
REQ-032 SHALL cover: read len=4 adr 0x40, rty on beat 2 -> 2-cycle cyc gap, restart at 0x44 with cti 010,010,111; rty repeated 5 times at max_retry=4 -> done_err=1.
